adc_spi_sampler: RTL

Periodic SPI ADC sampler for the datalogger front end. On a programmable sample tick it reads one 16-bit frame from an external 12-bit SPI ADC and publishes a 32-bit status/sample word. That word drives the `in_port` of the 32-bit Avalon parallel input port; software polls it over the HPS bridge. The word carries a sequence count and a missed-sample flag, so software can detect new and dropped samples without any handshake back to this block.

---
 rtl/adc_spi_sampler.sv | 72 +++++++
 1 files changed

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic 12-bit SPI ADC reader publishing a sequenced status/sample word
// for a polled parallel input port.
module adc_spi_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [31:0] sample_word,
    output logic        sample_valid
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t        state, state_next;
    logic [PW-1:0] period_cnt;
    logic [DW-1:0] div_cnt;
    logic [4:0]    half_cnt;
    logic [11:0]   shreg;
    logic [15:0]   seq;
    logic          missed, trigger, phase_end, publish;

    always_comb begin
        trigger    = enable && period_cnt == '0;
        phase_end  = div_cnt == DW'(CLK_DIV - 1);
        publish    = state == HOLD && phase_end;
        state_next = state;
        case (state)
            IDLE:    state_next = trigger ? SETUP : IDLE;
            SETUP:   state_next = phase_end ? SHIFT : SETUP;
            SHIFT:   state_next = phase_end && half_cnt == 5'd31 ? HOLD : SHIFT;
            default: state_next = phase_end ? IDLE : HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_next;

    // Only the last 12 bits shifted in survive, which drops the 4 leading frame bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt   <= '0;
            div_cnt      <= '0;
            half_cnt     <= '0;
            shreg        <= '0;
            seq          <= '0;
            missed       <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample_word  <= '0;
            sample_valid <= 1'b0;
        end else begin
            period_cnt   <= !enable || period_cnt == PW'(SAMPLE_PERIOD - 1) ? '0 : period_cnt + 1'b1;
            div_cnt      <= state == IDLE || phase_end ? '0 : div_cnt + 1'b1;
            half_cnt     <= state == SHIFT && phase_end ? half_cnt + 5'd1 : half_cnt;
            adc_cs_n     <= state == IDLE && trigger ? 1'b0 : publish ? 1'b1 : adc_cs_n;
            adc_sclk     <= state == SHIFT && phase_end ? !half_cnt[0] : adc_sclk;
            shreg        <= state == SHIFT && phase_end && !half_cnt[0] ? {shreg[10:0], adc_miso} : shreg;
            seq          <= publish ? seq + 16'd1 : seq;
            missed       <= publish ? trigger : trigger && state != IDLE ? 1'b1 : missed;
            sample_word  <= publish ? {seq + 16'd1, missed, 3'b000, shreg} : sample_word;
            sample_valid <= publish;
        end
    end
endmodule
